ccx_responder: RTL and testbench

- FPGA-side responder for the FazyRV ExoTiny custom-instruction (CCX) port in the ECP5 emulation build.
- Receives chunk-serial operands rs_a/rs_b from the chip, executes the selected custom operation chunk by chunk, and streams the result back at a fixed latency.
- Asserts ccx_resp with the last result chunk.
- Sits in the emulation wrapper between the chip's uo_out/uio_oe outputs and its ui_in/uio_in inputs. It replaces the ad-hoc AND/shift-register emulation.

---
 rtl/ccx_responder.sv | 136 +++++++++++++
 tb/tb_ccx_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ccx_responder.sv
// CCX custom-instruction responder: chunk-serial AND/ADD with a fixed-latency result stream.
// Optional CCX_STATS_EN adds saturating done/drop counters.
module ccx_responder #(
  parameter int CHUNKSIZE = 4,
  parameter int RES_DLY   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ccx_req_i,
  input  logic                 ccx_sel_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
  output logic [CHUNKSIZE-1:0] ccx_res_o,
  output logic                 ccx_resp_o
`ifdef CCX_STATS_EN
  ,
  output logic [15:0]          stat_done_o,
  output logic [15:0]          stat_drop_o
`endif
);

  localparam int N  = 32 / CHUNKSIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic          carry_q, carry_d;

  logic                 take;
  logic                 last;
  logic                 op_use;
  logic                 cin;
  logic [CHUNKSIZE:0]   sum;
  logic [CHUNKSIZE-1:0] res_c;

  logic [RES_DLY-1:0]                vld_q;
  logic [RES_DLY-1:0]                lst_q;
  logic [RES_DLY-1:0][CHUNKSIZE-1:0] dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      carry_q <= carry_d;
    end
  end

  // Chunk 0 uses the live select and a zero carry-in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    take    = 1'b0;
    last    = 1'b0;
    op_use  = op_q;
    cin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ccx_req_i) begin
          take   = 1'b1;
          op_use = ccx_sel_i;
          op_d   = ccx_sel_i;
          last   = (N == 1);
          if (N > 1) begin
            state_d = RECV;
            cnt_d   = CW'(1);
          end
        end
      end
      RECV: begin
        take  = 1'b1;
        cin   = carry_q;
        last  = (cnt_q == CW'(N - 1));
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
    sum = {1'b0, ccx_rs_a_i}
        + {1'b0, ccx_rs_b_i}
        + {{CHUNKSIZE{1'b0}}, cin};
    res_c   = op_use ? sum[CHUNKSIZE-1:0]
                     : (ccx_rs_a_i & ccx_rs_b_i);
    carry_d = take ? sum[CHUNKSIZE] : carry_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      lst_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= take;
      lst_q[0] <= take & last;
      dat_q[0] <= take ? res_c : '0;
      for (int i = 1; i < RES_DLY; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign ccx_res_o  = vld_q[RES_DLY-1] ? dat_q[RES_DLY-1] : '0;
  assign ccx_resp_o = vld_q[RES_DLY-1] & lst_q[RES_DLY-1];

`ifdef CCX_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_done_o <= '0;
      stat_drop_o <= '0;
    end else begin
      if (ccx_resp_o && stat_done_o != 16'hFFFF)
        stat_done_o <= stat_done_o + 16'd1;
      if (state_q == RECV && ccx_req_i && stat_drop_o != 16'hFFFF)
        stat_drop_o <= stat_drop_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccx_responder.sv
// Directed bench for ccx_responder at default parameters (4-bit chunks, 5-cycle latency).
module tb_ccx_responder;

  localparam int CS  = 4;
  localparam int DLY = 5;
  localparam int NC  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          sel = 1'b0;
  logic [CS-1:0] rs_a = '0;
  logic [CS-1:0] rs_b = '0;
  logic [CS-1:0] res;
  logic          resp;
`ifdef CCX_STATS_EN
  logic [15:0]   st_done;
  logic [15:0]   st_drop;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;

  logic [CS-1:0] mon_res [0:1023];
  logic          mon_resp[0:1023];

  ccx_responder #(.CHUNKSIZE(CS), .RES_DLY(DLY)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ccx_req_i  (req),
    .ccx_sel_i  (sel),
    .ccx_rs_a_i (rs_a),
    .ccx_rs_b_i (rs_b),
    .ccx_res_o  (res),
    .ccx_resp_o (resp)
`ifdef CCX_STATS_EN
    ,
    .stat_done_o(st_done),
    .stat_drop_o(st_drop)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cyc < 1024) begin
      mon_res[cyc]  = res;
      mon_resp[cyc] = resp;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gather(input int t);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < NC; k++)
      r[k*CS +: CS] = mon_res[t + DLY + k];
    return r;
  endfunction

  function automatic int resp_cnt(input int from, input int to);
    int n;
    n = 0;
    for (int c = from; c <= to; c++)
      if (mon_resp[c] === 1'b1) n++;
    return n;
  endfunction

  // Entered and left at #1 after a rising edge; t is the req cycle.
  task automatic send(input logic s,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input int inj,
                      output int t);
    t = cyc;
    for (int k = 0; k < NC; k++) begin
      req  = (k == 0) || (k == inj);
      sel  = (k == 0) ? s : 1'b1;
      rs_a = a[k*CS +: CS];
      rs_b = b[k*CS +: CS];
      @(posedge clk); #1;
    end
    req  = 1'b0;
    sel  = 1'b0;
    rs_a = '0;
    rs_b = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    wait_cyc(3);
    check("rst_res", 32'(res), 32'h0);
    check("rst_resp", 32'(resp), 32'h0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Req during RECV at t0+3 must be ignored
    send(1'b0, 32'hF0F0_1234, 32'hFF00_00FF, 3, t0);
    wait_cyc(6);
    check("drop_res", gather(t0), 32'hF000_0034);
    check("drop_resp_pos", 32'(mon_resp[t0+12]), 32'h1);
    check("drop_resp_cnt", resp_cnt(t0, t0+20), 32'h1);
`ifdef CCX_STATS_EN
    check("stat_drop", 32'(st_drop), 32'h1);
    check("stat_done", 32'(st_done), 32'h1);
`endif

    send(1'b0, 32'hF0F0_1234, 32'hFF00_00FF, -1, t0);
    wait_cyc(6);
    check("and_res", gather(t0), 32'hF000_0034);
    check("and_n0", 32'(mon_res[t0+5]), 32'h4);
    check("and_n1", 32'(mon_res[t0+6]), 32'h3);
    check("and_resp_pos", 32'(mon_resp[t0+12]), 32'h1);
    check("and_resp_cnt", resp_cnt(t0+5, t0+13), 32'h1);
    check("and_tail", 32'(mon_res[t0+13]), 32'h0);

    send(1'b1, 32'h0000_000F, 32'h0000_0001, -1, t0);
    wait_cyc(6);
    check("add_res", gather(t0), 32'h0000_0010);
    check("add_n1", 32'(mon_res[t0+6]), 32'h1);
    check("add_resp_pos", 32'(mon_resp[t0+12]), 32'h1);

    send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, -1, t0);
    wait_cyc(6);
    check("wrap_res", gather(t0), 32'h0);
    check("wrap_resp_cnt", resp_cnt(t0+5, t0+13), 32'h1);

    begin
      int t1;
      send(1'b1, 32'h1, 32'h2, -1, t0);
      send(1'b0, 32'hFFFF_FFFF, 32'h1234_5678, -1, t1);
      wait_cyc(6);
      check("b2b_t1", t1 - t0, 32'd8);
      check("b2b_res0", gather(t0), 32'h0000_0003);
      check("b2b_res1", gather(t0+8), 32'h1234_5678);
      check("b2b_resp0", 32'(mon_resp[t0+12]), 32'h1);
      check("b2b_resp1", 32'(mon_resp[t0+20]), 32'h1);
      check("b2b_resp_cnt", resp_cnt(t0+5, t0+21), 32'h2);
      check("b2b_tail", 32'(mon_res[t0+21]), 32'h0);
    end

    // Reset lands in cycle t0+6 of an ADD whose chunk 0 is already out
    t0 = cyc;
    for (int k = 0; k < NC; k++) begin
      if (k == 6) begin
        rst_n = 1'b0;
        #1;
        check("arst_res", 32'(res), 32'h0);
        check("arst_resp", 32'(resp), 32'h0);
      end
      req  = (k == 0);
      sel  = 1'b1;
      rs_a = 4'h7;
      rs_b = 4'h9;
      @(posedge clk); #1;
    end
    req = 1'b0;
    rst_n = 1'b1;
    wait_cyc(14);
    check("arst_no_resp", resp_cnt(t0+6, t0+21), 32'h0);
`ifdef CCX_STATS_EN
    check("arst_stat", 32'(st_done), 32'h0);
`endif

    send(1'b1, 32'h1234_5678, 32'h1111_1111, -1, t0);
    wait_cyc(6);
    check("post_res", gather(t0), 32'h2345_6789);
    check("post_resp_pos", 32'(mon_resp[t0+12]), 32'h1);
    check("post_resp_cnt", resp_cnt(t0+5, t0+13), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
